// File: rtl/mul_fp_pipe.sv
// mul_fp_pipe: pipelined, multi-lane, mixed-format FP x FP multiplier.
// Each lane produces the exact signed fixed-point product of its two
// operands. No rounding is applied and the result cannot overflow.
//
// Optional feature macro: MUL_FP_PIPE_SPECIAL_EN
//   When this macro is defined, the o_special port is present. A lane whose
//   operand has an all-ones exponent is flagged on o_special and its product
//   is forced to zero. When the macro is undefined, all-ones exponents are
//   treated as ordinary normal values.
//
// Handshake (applies to both sides):
//   A beat transfers on a rising edge where valid and ready are both high.
//   Once valid is raised, it stays high and its payload stays stable until
//   the transfer completes. Ready never depends on valid from the same side.
//
// Pipeline:
//   S1 unpacks the fields and forms the signed mantissas and the shift sum.
//   S2 forms the mantissa product.
//   S3 barrel-shifts the product into PRD_W bits.
//   A stage loads when it is empty or when its downstream stage loads, so
//   empty slots (bubbles) collapse even while the output is stalled.
module mul_fp_pipe #(
  parameter  int LANES  = 4,
  parameter  int EXP0_W = 5,
  parameter  int MAN0_W = 2,
  parameter  int EXP1_W = 5,
  parameter  int MAN1_W = 2,
  localparam int BIT0_W = 1 + EXP0_W + MAN0_W,
  localparam int BIT1_W = 1 + EXP1_W + MAN1_W,
  localparam int PRD_W  = (1 << EXP0_W) + MAN0_W + (1 << EXP1_W) + MAN1_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [LANES*BIT0_W-1:0] i_op0,
  input  logic [LANES*BIT1_W-1:0] i_op1,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [LANES*PRD_W-1:0]  o_prd
`ifdef MUL_FP_PIPE_SPECIAL_EN
  ,
  output logic [LANES-1:0]        o_special
`endif
);

  // Signed mantissa widths: hidden bit + mantissa + sign.
  localparam int SM0_W = MAN0_W + 2;
  localparam int SM1_W = MAN1_W + 2;
  localparam int MP_W  = SM0_W + SM1_W;
  // Shift sum reaches at most 2^EXP0_W + 2^EXP1_W - 4.
  // Two bits above the wider exponent are therefore sufficient.
  localparam int SH_W  = ((EXP0_W > EXP1_W) ? EXP0_W : EXP1_W) + 2;

  // ---------------------------------------------------------------------------
  // Per-operand field helpers
  // ---------------------------------------------------------------------------
  function automatic logic signed [SM0_W-1:0] signed_man0(input logic [BIT0_W-1:0] op);
    logic [SM0_W-1:0] mag;
    mag = {1'b0, |op[MAN0_W +: EXP0_W], op[MAN0_W-1:0]};
    return op[BIT0_W-1] ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic logic signed [SM1_W-1:0] signed_man1(input logic [BIT1_W-1:0] op);
    logic [SM1_W-1:0] mag;
    mag = {1'b0, |op[MAN1_W +: EXP1_W], op[MAN1_W-1:0]};
    return op[BIT1_W-1] ? -$signed(mag) : $signed(mag);
  endfunction

  // Subnormals (exp == 0) share the scale of exp == 1, so the shift is exp - nrm.
  function automatic logic [SH_W-1:0] shift0(input logic [BIT0_W-1:0] op);
    logic [EXP0_W-1:0] e;
    e = op[MAN0_W +: EXP0_W];
    return SH_W'(e) - SH_W'(|e);
  endfunction

  function automatic logic [SH_W-1:0] shift1(input logic [BIT1_W-1:0] op);
    logic [EXP1_W-1:0] e;
    e = op[MAN1_W +: EXP1_W];
    return SH_W'(e) - SH_W'(|e);
  endfunction

  // ---------------------------------------------------------------------------
  // Stage state
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s3_valid_q, s3_valid_d;
  logic s1_load, s2_load, s3_load;

  logic signed [SM0_W-1:0] s1_sman0_q [LANES];
  logic signed [SM0_W-1:0] s1_sman0_d [LANES];
  logic signed [SM1_W-1:0] s1_sman1_q [LANES];
  logic signed [SM1_W-1:0] s1_sman1_d [LANES];
  logic        [SH_W-1:0]  s1_sh_q    [LANES];
  logic        [SH_W-1:0]  s1_sh_d    [LANES];

  logic signed [MP_W-1:0]  s2_mp_q    [LANES];
  logic signed [MP_W-1:0]  s2_mp_d    [LANES];
  logic        [SH_W-1:0]  s2_sh_q    [LANES];
  logic        [SH_W-1:0]  s2_sh_d    [LANES];

  logic signed [PRD_W-1:0] s3_prd_q   [LANES];
  logic signed [PRD_W-1:0] s3_prd_d   [LANES];

`ifdef MUL_FP_PIPE_SPECIAL_EN
  logic [LANES-1:0] s1_spc_q, s1_spc_d;
  logic [LANES-1:0] s2_spc_q, s2_spc_d;
  logic [LANES-1:0] s3_spc_q, s3_spc_d;
`endif

  // Load enables cascade back from the output.
  // Each stage's next valid bit follows from its load enable.
  always_comb begin
    s3_load    = !s3_valid_q || i_ready;
    s2_load    = !s2_valid_q || s3_load;
    s1_load    = !s1_valid_q || s2_load;
    s1_valid_d = s1_load ? i_valid    : s1_valid_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    s3_valid_d = s3_load ? s2_valid_q : s3_valid_q;
  end

  assign o_ready = s1_load;
  assign o_valid = s3_valid_q;

  // Valid bits; reset discards every in-flight beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
    end
  end

  // S1: unpack fields, build signed mantissas and the combined shift amount.
  always_comb begin
`ifdef MUL_FP_PIPE_SPECIAL_EN
    s1_spc_d = s1_spc_q;
`endif
    for (int k = 0; k < LANES; k++) begin
      s1_sman0_d[k] = s1_sman0_q[k];
      s1_sman1_d[k] = s1_sman1_q[k];
      s1_sh_d[k]    = s1_sh_q[k];
      if (s1_load && i_valid) begin
        s1_sman0_d[k] = signed_man0(i_op0[k*BIT0_W +: BIT0_W]);
        s1_sman1_d[k] = signed_man1(i_op1[k*BIT1_W +: BIT1_W]);
        s1_sh_d[k]    = shift0(i_op0[k*BIT0_W +: BIT0_W])
                      + shift1(i_op1[k*BIT1_W +: BIT1_W]);
`ifdef MUL_FP_PIPE_SPECIAL_EN
        s1_spc_d[k]   = (&i_op0[k*BIT0_W + MAN0_W +: EXP0_W])
                      | (&i_op1[k*BIT1_W + MAN1_W +: EXP1_W]);
`endif
      end
    end
  end

  // S1 registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        s1_sman0_q[k] <= '0;
        s1_sman1_q[k] <= '0;
        s1_sh_q[k]    <= '0;
      end
`ifdef MUL_FP_PIPE_SPECIAL_EN
      s1_spc_q <= '0;
`endif
    end else begin
      for (int k = 0; k < LANES; k++) begin
        s1_sman0_q[k] <= s1_sman0_d[k];
        s1_sman1_q[k] <= s1_sman1_d[k];
        s1_sh_q[k]    <= s1_sh_d[k];
      end
`ifdef MUL_FP_PIPE_SPECIAL_EN
      s1_spc_q <= s1_spc_d;
`endif
    end
  end

  // S2: signed mantissa product; both operands are sign-extended to the full product width.
  always_comb begin
`ifdef MUL_FP_PIPE_SPECIAL_EN
    s2_spc_d = s2_spc_q;
`endif
    for (int k = 0; k < LANES; k++) begin
      s2_mp_d[k] = s2_mp_q[k];
      s2_sh_d[k] = s2_sh_q[k];
      if (s2_load && s1_valid_q) begin
        s2_mp_d[k] = $signed({{SM1_W{s1_sman0_q[k][SM0_W-1]}}, s1_sman0_q[k]})
                   * $signed({{SM0_W{s1_sman1_q[k][SM1_W-1]}}, s1_sman1_q[k]});
        s2_sh_d[k] = s1_sh_q[k];
`ifdef MUL_FP_PIPE_SPECIAL_EN
        s2_spc_d[k] = s1_spc_q[k];
`endif
      end
    end
  end

  // S2 registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        s2_mp_q[k] <= '0;
        s2_sh_q[k] <= '0;
      end
`ifdef MUL_FP_PIPE_SPECIAL_EN
      s2_spc_q <= '0;
`endif
    end else begin
      for (int k = 0; k < LANES; k++) begin
        s2_mp_q[k] <= s2_mp_d[k];
        s2_sh_q[k] <= s2_sh_d[k];
      end
`ifdef MUL_FP_PIPE_SPECIAL_EN
      s2_spc_q <= s2_spc_d;
`endif
    end
  end

  // S3: sign-extend the product to PRD_W, then shift left by the exponent sum.
  always_comb begin
`ifdef MUL_FP_PIPE_SPECIAL_EN
    s3_spc_d = s3_spc_q;
`endif
    for (int k = 0; k < LANES; k++) begin
      s3_prd_d[k] = s3_prd_q[k];
      if (s3_load && s2_valid_q) begin
        s3_prd_d[k] = {{(PRD_W-MP_W){s2_mp_q[k][MP_W-1]}}, s2_mp_q[k]} << s2_sh_q[k];
`ifdef MUL_FP_PIPE_SPECIAL_EN
        s3_spc_d[k] = s2_spc_q[k];
        if (s2_spc_q[k]) begin
          s3_prd_d[k] = '0;
        end
`endif
      end
    end
  end

  // S3 registers. These drive the outputs directly, so they hold while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        s3_prd_q[k] <= '0;
      end
`ifdef MUL_FP_PIPE_SPECIAL_EN
      s3_spc_q <= '0;
`endif
    end else begin
      for (int k = 0; k < LANES; k++) begin
        s3_prd_q[k] <= s3_prd_d[k];
      end
`ifdef MUL_FP_PIPE_SPECIAL_EN
      s3_spc_q <= s3_spc_d;
`endif
    end
  end

  // Pack the lane products onto the output bus.
  always_comb begin
    o_prd = '0;
    for (int k = 0; k < LANES; k++) begin
      o_prd[k*PRD_W +: PRD_W] = s3_prd_q[k];
    end
  end

`ifdef MUL_FP_PIPE_SPECIAL_EN
  assign o_special = s3_spc_q;
`endif

endmodule

// File: tb/tb_mul_fp_pipe.sv
// tb_mul_fp_pipe: directed-vector bench for mul_fp_pipe.
// The main DUT uses the default E5M2 x E5M2 configuration with four lanes.
// A second instance uses E4M3 x E5M2 with a single lane.
// Expected lane products are written by hand in a vector table.
`timescale 1ns/1ps
module tb_mul_fp_pipe;

  localparam int LANES = 4;
  localparam int BIT_W = 8;
  localparam int PRD_W = 68;
  localparam int CW    = LANES * PRD_W;
  localparam int MIX_PRD_W = 53;
  localparam int NVEC  = 12;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                   i_valid, o_ready, o_valid, i_ready;
  logic [LANES*BIT_W-1:0] i_op0, i_op1;
  logic [CW-1:0]          o_prd;

  logic                 m_valid, m_ready, m_ovalid, m_iready;
  logic [7:0]           m_op0, m_op1;
  logic [MIX_PRD_W-1:0] m_prd;

`ifdef MUL_FP_PIPE_SPECIAL_EN
  logic [LANES-1:0] o_special;
  logic             m_special;
`endif

  mul_fp_pipe u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op0   (i_op0),
    .i_op1   (i_op1),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_prd   (o_prd)
`ifdef MUL_FP_PIPE_SPECIAL_EN
    ,
    .o_special (o_special)
`endif
  );

  mul_fp_pipe #(.LANES(1), .EXP0_W(4), .MAN0_W(3), .EXP1_W(5), .MAN1_W(2)) u_mix (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (m_valid),
    .o_ready (m_ready),
    .i_op0   (m_op0),
    .i_op1   (m_op1),
    .o_valid (m_ovalid),
    .i_ready (m_iready),
    .o_prd   (m_prd)
`ifdef MUL_FP_PIPE_SPECIAL_EN
    ,
    .o_special (m_special)
`endif
  );

  // ---------------------------------------------------------------------------
  // Vector table (hand-computed E5M2 x E5M2 products, 68-bit two's complement)
  // ---------------------------------------------------------------------------
  logic [7:0]       t_op0 [NVEC];
  logic [7:0]       t_op1 [NVEC];
  logic [PRD_W-1:0] t_prd [NVEC];
  logic             t_spc [NVEC];

  task automatic set_vec(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [PRD_W-1:0] p, input logic s);
    t_op0[i] = a; t_op1[i] = b; t_prd[i] = p; t_spc[i] = s;
  endtask

  task automatic init_table();
    set_vec(0,  8'h3C, 8'h3C, 68'h0_0000_0001_0000_0000, 1'b0); // 2^16 * 2^16
    set_vec(1,  8'h01, 8'h01, 68'h0_0000_0000_0000_0001, 1'b0); // subnormal 1*1
    set_vec(2,  8'hBC, 8'h3C, 68'hF_FFFF_FFFF_0000_0000, 1'b0); // -2^32
    set_vec(3,  8'h00, 8'h7B, 68'h0_0000_0000_0000_0000, 1'b0); // zero
    set_vec(4,  8'h80, 8'h3C, 68'h0_0000_0000_0000_0000, 1'b0); // signed zero
    set_vec(5,  8'h02, 8'h03, 68'h0_0000_0000_0000_0006, 1'b0); // 2*3
    set_vec(6,  8'h05, 8'h84, 68'hF_FFFF_FFFF_FFFF_FFEC, 1'b0); // 5*-4
    set_vec(7,  8'h08, 8'h03, 68'h0_0000_0000_0000_0018, 1'b0); // 8*3
    set_vec(8,  8'h3D, 8'h01, 68'h0_0000_0000_0001_4000, 1'b0); // (5<<14)*1
    set_vec(9,  8'h7F, 8'h7F, 68'h3_1000_0000_0000_0000, 1'b1); // 49<<60
    set_vec(10, 8'hFF, 8'h7F, 68'hC_F000_0000_0000_0000, 1'b1); // -(49<<60)
    set_vec(11, 8'h7F, 8'h01, 68'h0_0000_0001_C000_0000, 1'b1); // 7<<30
  endtask

  function automatic logic [PRD_W-1:0] lane_exp(input int i);
`ifdef MUL_FP_PIPE_SPECIAL_EN
    return t_spc[i] ? '0 : t_prd[i];
`else
    return t_prd[i];
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [CW-1:0]    exp_q     [$];
  logic [LANES-1:0] exp_spc_q [$];
  int n_checks = 0;
  int n_pass   = 0;
  int hs_cyc   = 0;

  task automatic check(input bit ok, input string name,
                       input logic [CW-1:0] act, input logic [CW-1:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1; return at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic send_lanes(input int l0, input int l1, input int l2, input int l3);
    int               sel [LANES];
    logic [CW-1:0]    e;
    logic [LANES-1:0] es;
    bit               done;
    sel[0] = l0; sel[1] = l1; sel[2] = l2; sel[3] = l3;
    e = '0; es = '0;
    for (int k = 0; k < LANES; k++) begin
      i_op0[k*BIT_W +: BIT_W] = t_op0[sel[k]];
      i_op1[k*BIT_W +: BIT_W] = t_op1[sel[k]];
      e[k*PRD_W +: PRD_W]     = lane_exp(sel[k]);
      es[k]                   = t_spc[sel[k]];
    end
    i_valid = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (o_ready) begin
        exp_q.push_back(e);
        exp_spc_q.push_back(es);
        hs_cyc = cyc;
        done = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    if (!done) check(1'b0, "send_timeout", CW'(o_ready), CW'(1));
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check(exp_q.size() == 0, "drain", CW'(exp_q.size()), CW'(0));
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Output monitor: pop and compare on every output handshake; check hold
  // ---------------------------------------------------------------------------
  logic [CW-1:0]    held_prd;
  bit               held = 1'b0;
  logic [CW-1:0]    mon_e;
  logic [LANES-1:0] mon_es;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) check(o_valid === 1'b1 && o_prd === held_prd, "hold", o_prd, held_prd);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_out", o_prd, '0);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_es = exp_spc_q.pop_front();
          check(o_prd === mon_e, "prd", o_prd, mon_e);
`ifdef MUL_FP_PIPE_SPECIAL_EN
          check(o_special === mon_es, "special", CW'(o_special), CW'(mon_es));
`endif
        end
        held = 1'b0;
      end else if (o_valid) begin
        held = 1'b1;
        held_prd = o_prd;
      end else begin
        held = 1'b0;
      end
    end
  end

  // Occupancy model: ready must stay high unless three beats are in flight with no output transfer.
  int occ = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0;
    end else begin
      check(o_ready === ((occ < 3) || i_ready), "o_ready", CW'(o_ready),
            CW'((occ < 3) || i_ready));
      occ = occ + int'(i_valid && o_ready) - int'(o_valid && i_ready);
    end
  end

  // Downstream ready toggler, pattern 1,0,0,1.
  bit       tog_en  = 1'b0;
  int       tog_idx = 0;
  logic [3:0] tog_pat = 4'b1001;
  always @(posedge clk) begin
    #1;
    if (tog_en) begin
      i_ready = tog_pat[tog_idx];
      tog_idx = (tog_idx + 1) % 4;
    end
  end

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int stale;

  initial begin
    init_table();
    i_valid = 1'b0; i_ready = 1'b1; i_op0 = '0; i_op1 = '0;
    m_valid = 1'b0; m_iready = 1'b1; m_op0 = '0; m_op1 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(o_valid === 1'b0, "rst_valid", CW'(o_valid), CW'(0));
    check(o_prd === '0, "rst_prd", o_prd, '0);
`ifdef MUL_FP_PIPE_SPECIAL_EN
    check(o_special === '0, "rst_special", CW'(o_special), CW'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check(o_ready === 1'b1, "rst_ready", CW'(o_ready), CW'(1));
    @(posedge clk);
    #1;

    // Latency: all lanes 0x3C x 0x3C with an empty pipe and i_ready held at 1.
    send_lanes(0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_valid) break;
    end
    check(cyc - hs_cyc == 3, "latency", CW'(cyc - hs_cyc), CW'(3));
    drain();

    // Lane mix, all-ones exponents, and assorted vectors.
    send_lanes(1, 2, 3, 4);
    send_lanes(9, 9, 9, 9);
    send_lanes(5, 6, 7, 8);
    send_lanes(10, 11, 0, 2);
    drain();

    // Continuous input with output ready toggling 1,0,0,1.
    tog_en = 1'b1;
    for (int b = 0; b < 8; b++) send_lanes(b % NVEC, (b + 3) % NVEC, (b + 5) % NVEC, (b + 7) % NVEC);
    drain();
    tog_en = 1'b0;
    @(posedge clk);
    #1;
    i_ready = 1'b1;

    // One beat, 5-cycle stall, two more beats, then release: expect a 3-beat back-to-back drain.
    i_ready = 1'b0;
    send_lanes(0, 1, 2, 3);
    repeat (5) @(posedge clk);
    #1;
    send_lanes(4, 5, 6, 7);
    send_lanes(8, 9, 10, 11);
    i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check(o_valid === 1'b1, "drain_consec", CW'(o_valid), CW'(1));
    end
    drain();

    // Asynchronous reset mid-cycle with three beats in flight.
    i_ready = 1'b0;
    send_lanes(0, 0, 0, 0);
    send_lanes(1, 1, 1, 1);
    send_lanes(2, 2, 2, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check(o_valid === 1'b0, "async_rst_valid", CW'(o_valid), CW'(0));
    check(o_prd === '0, "async_rst_prd", o_prd, '0);
    exp_q.delete();
    exp_spc_q.delete();
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_valid) stale++;
    end
    check(stale == 0, "no_stale", CW'(stale), CW'(0));
    @(posedge clk);
    #1;
    send_lanes(3, 4, 5, 6);
    drain();

    // Mixed format: E4M3 0x38 x E5M2 0x3C = (8<<6)*(4<<14) = 2^25.
    m_op0 = 8'h38;
    m_op1 = 8'h3C;
    m_valid = 1'b1;
    @(negedge clk);
    check(m_ready === 1'b1, "mix_ready", CW'(m_ready), CW'(1));
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_ovalid) break;
    end
    check(m_ovalid === 1'b1 && m_prd === 53'h200_0000, "mix_prd", CW'(m_prd), CW'(53'h200_0000));
    @(posedge clk);
    #1;

    check(exp_q.size() == 0, "queue_empty", CW'(exp_q.size()), CW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
